// File: rtl/keycode_evt_pkg.sv
// Shared types and constants for the keycode event generator.
// Event encoding, FSM states and the FIFO word format live here.
package keycode_evt_pkg;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_REPEAT  = 2'b11
    } evt_type_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REL,
        S_PRESS
    } state_t;

    // "type" is a reserved word, so the kind field is named etype.
    typedef struct packed {
        evt_type_t  etype;
        logic [7:0] code;
    } evt_t;

    localparam logic [7:0] KEY_NONE = 8'h00;

    function automatic evt_t make_evt(input evt_type_t t, input logic [7:0] c);
        evt_t e;
        e.etype = t;
        e.code  = c;
        return e;
    endfunction

endpackage

// File: rtl/keycode_evt_fifo.sv
// First-word-fall-through event FIFO with a sticky drop flag.
// Simultaneous push and pop are both honoured even when full.
module keycode_evt_fifo
    import keycode_evt_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  evt_t push_evt,
    input  logic pop_ready,
    input  logic ovf_clear,
    output logic head_valid,
    output evt_t head_evt,
    output logic ovf
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    evt_t          mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          pop;
    logic          wr_en;
    logic          drop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = !empty && pop_ready;
    // A pop frees the head slot this same edge, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign head_valid = !empty;
    assign head_evt   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clear) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/keycode_event_gen.sv
// Turns the level-style keycode from the SoC PIO into a buffered stream
// of press / release / auto-repeat events with a stability filter.
module keycode_event_gen
    import keycode_evt_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter int unsigned DEPTH         = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode_in,
    input  logic       ovf_clear,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_type,
    output logic [7:0] evt_code,
    output logic [7:0] cur_key,
    output logic       ovf
);

    localparam int unsigned SW   = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [7:0]    cand;
    logic [SW-1:0] cnt;
    logic [SW-1:0] cnt_next;
    logic [7:0]    old_key;
    state_t        state;
    logic [RW-1:0] rpt_cnt;
    logic          accept;
    logic          rpt_fire;
    logic          push;
    evt_t          push_evt;
    evt_t          head_evt;

    // Acceptance looks at the count this edge will store, so a key held from
    // cycle t is taken on the edge that ends cycle t+STABLE_CYCLES-1.
    always_comb begin
        if (keycode_in != cand) begin
            cnt_next = SW'(1);
        end else if (cnt < SW'(STABLE_CYCLES)) begin
            cnt_next = cnt + SW'(1);
        end else begin
            cnt_next = cnt;
        end
    end

    assign accept   = (state == S_IDLE) && (cnt_next == SW'(STABLE_CYCLES))
                      && (keycode_in != cur_key);
    assign rpt_fire = (state == S_IDLE) && !accept && (cur_key != KEY_NONE)
                      && (rpt_cnt == RW'(1));

    always_comb begin
        push     = 1'b0;
        push_evt = '0;
        case (state)
            S_REL: begin
                push     = 1'b1;
                push_evt = make_evt(EVT_RELEASE, old_key);
            end
            S_PRESS: begin
                push     = 1'b1;
                push_evt = make_evt(EVT_PRESS, cur_key);
            end
            default: begin
                if (rpt_fire) begin
                    push     = 1'b1;
                    push_evt = make_evt(EVT_REPEAT, cur_key);
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cand    <= KEY_NONE;
            cnt     <= '0;
            old_key <= KEY_NONE;
            cur_key <= KEY_NONE;
            rpt_cnt <= '0;
            state   <= S_IDLE;
        end else begin
            cand <= keycode_in;
            cnt  <= cnt_next;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        old_key <= cur_key;
                        cur_key <= keycode_in;
                        rpt_cnt <= '0;
                        state   <= (cur_key != KEY_NONE) ? S_REL : S_PRESS;
                    end else if (cur_key != KEY_NONE && rpt_cnt != '0) begin
                        rpt_cnt <= rpt_fire ? RW'(REPEAT_PERIOD) : rpt_cnt - RW'(1);
                    end
                end
                S_REL: begin
                    state <= (cur_key != KEY_NONE) ? S_PRESS : S_IDLE;
                end
                S_PRESS: begin
                    rpt_cnt <= RW'(REPEAT_DELAY);
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    keycode_evt_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .reset     (Reset),
        .push      (push),
        .push_evt  (push_evt),
        .pop_ready (evt_ready),
        .ovf_clear (ovf_clear),
        .head_valid(evt_valid),
        .head_evt  (head_evt),
        .ovf       (ovf)
    );

    assign evt_type = head_evt.etype;
    assign evt_code = head_evt.code;

endmodule
